// File: rtl/irrigation_timer_bcd_pkg.sv
// Shared codes, FSM encoding and BCD preset table for the irrigation countdown timer.
package irrigation_timer_pkg;

  localparam logic [1:0] STATE_IDLE       = 2'b00;
  localparam logic [1:0] STATE_VALVE_OPEN = 2'b01;
  localparam logic [1:0] STATE_IRRIGATE   = 2'b10;
  localparam logic [1:0] STATE_DRAIN      = 2'b11;

  localparam logic [1:0] TYPE_SPRINKLER = 2'b00;
  localparam logic [1:0] TYPE_DRIP      = 2'b01;
  localparam logic [1:0] TYPE_MIST      = 2'b10;
  localparam logic [1:0] TYPE_NONE      = 2'b11;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'b00,
    FSM_RUN    = 2'b01,
    FSM_PAUSED = 2'b10
  } fsm_state_e;

  localparam logic [7:0] PRESET_IDLE       = 8'h00;
  localparam logic [7:0] PRESET_VALVE_OPEN = 8'h10;
  localparam logic [7:0] PRESET_SPRINKLER  = 8'h45;
  localparam logic [7:0] PRESET_DRIP       = 8'h90;
  localparam logic [7:0] PRESET_MIST       = 8'h30;
  localparam logic [7:0] PRESET_NONE       = 8'h00;
  localparam logic [7:0] PRESET_DRAIN      = 8'h05;

  function automatic logic [7:0] preset_bcd(input logic [1:0] ctrl_state,
                                            input logic [1:0] irr_type);
    logic [7:0] preset_v;
    preset_v = PRESET_NONE;
    case (ctrl_state)
      STATE_IDLE:       preset_v = PRESET_IDLE;
      STATE_VALVE_OPEN: preset_v = PRESET_VALVE_OPEN;
      STATE_IRRIGATE: begin
        case (irr_type)
          TYPE_SPRINKLER: preset_v = PRESET_SPRINKLER;
          TYPE_DRIP:      preset_v = PRESET_DRIP;
          TYPE_MIST:      preset_v = PRESET_MIST;
          TYPE_NONE:      preset_v = PRESET_NONE;
          default:        preset_v = PRESET_NONE;
        endcase
      end
      STATE_DRAIN:      preset_v = PRESET_DRAIN;
      default:          preset_v = PRESET_NONE;
    endcase
    return preset_v;
  endfunction

endpackage

// File: rtl/irrigation_timer_bcd_digit.sv
// One BCD countdown digit; borrow_in requests a decrement, borrow_out ripples to the next digit.
module bcd_digit_down (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_r;

  // Digit register: reset, clear, load, then decrement with 0 -> 9 wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_r <= 4'd0;
    end else if (clr) begin
      digit_r <= 4'd0;
    end else if (load) begin
      digit_r <= load_value;
    end else if (borrow_in) begin
      digit_r <= (digit_r == 4'd0) ? 4'd9 : (digit_r - 4'd1);
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit      = digit_r;
  assign borrow_out = borrow_in && (digit_r == 4'd0);

endmodule

// File: rtl/irrigation_timer_bcd.sv
// BCD countdown timer for the irrigation controller, paced by a prescaler enable.
module irrigation_timer_bcd #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state,
  input  logic [1:0]            irrigation_type,
  input  logic                  load,
  input  logic                  pause,
  input  logic                  abort,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  clk_off
);
  import irrigation_timer_pkg::*;

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  fsm_state_e    fsm_r, fsm_nx_s;
  logic [PW-1:0] presc_r, presc_nx_s;
  logic          done_r, done_nx_s;
  logic [7:0]    preset_s;
  logic [CW-1:0] preset_ext_s;
  logic [CW-1:0] count_s;
  logic [DIGITS:0] borrow_s;
  logic          tick_s, dec_s, underflow_s, clr_s, count_is_one_s, count_zero_s;

  assign preset_s       = preset_bcd(state, irrigation_type);
  assign preset_ext_s   = CW'(preset_s);
  assign tick_s         = (fsm_r == FSM_RUN) && (presc_r == PW'(TICK_DIV - 1));
  assign dec_s          = tick_s && !abort && !load;
  assign count_is_one_s = (count_s == CW'(1));
  assign count_zero_s   = ~|count_s;
  // A decrement from zero can only come from corrupted state; clamp to zero instead of wrapping.
  assign underflow_s    = borrow_s[DIGITS];
  assign clr_s          = abort || underflow_s;
  assign borrow_s[0]    = dec_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr_s),
      .load       (load),
      .load_value (preset_ext_s[4*g +: 4]),
      .borrow_in  (borrow_s[g]),
      .digit      (count_s[4*g +: 4]),
      .borrow_out (borrow_s[g+1])
    );
  end

  // Next-state logic: abort over load over tick/pause transitions.
  always_comb begin
    fsm_nx_s   = fsm_r;
    presc_nx_s = presc_r;
    done_nx_s  = 1'b0;
    if (abort) begin
      fsm_nx_s   = FSM_IDLE;
      presc_nx_s = {PW{1'b0}};
    end else if (load) begin
      presc_nx_s = {PW{1'b0}};
      if (preset_s == 8'h00) begin
        fsm_nx_s = FSM_IDLE;
      end else if (pause) begin
        fsm_nx_s = FSM_PAUSED;
      end else begin
        fsm_nx_s = FSM_RUN;
      end
    end else begin
      case (fsm_r)
        FSM_IDLE: begin
          presc_nx_s = {PW{1'b0}};
        end
        FSM_RUN: begin
          if (tick_s) begin
            presc_nx_s = {PW{1'b0}};
          end else begin
            presc_nx_s = presc_r + PW'(1);
          end
          if (tick_s && (count_is_one_s || underflow_s)) begin
            fsm_nx_s  = FSM_IDLE;
            done_nx_s = count_is_one_s;
          end else if (pause) begin
            fsm_nx_s = FSM_PAUSED;
          end else begin
            fsm_nx_s = FSM_RUN;
          end
        end
        FSM_PAUSED: begin
          if (pause) begin
            fsm_nx_s = FSM_PAUSED;
          end else begin
            fsm_nx_s = FSM_RUN;
          end
        end
        default: begin
          fsm_nx_s   = FSM_IDLE;
          presc_nx_s = {PW{1'b0}};
        end
      endcase
    end
  end

  // State, prescaler and done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r   <= FSM_IDLE;
      presc_r <= {PW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_nx_s;
      presc_r <= presc_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign count   = count_s;
  assign busy    = (fsm_r != FSM_IDLE);
  assign done    = done_r;
  assign clk_off = count_zero_s;

endmodule

// File: tb/tb_irrigation_timer_bcd.sv
// Randomized and directed bench for irrigation_timer_bcd (TICK_DIV=4) against a seconds-level model.
module tb_irrigation_timer_bcd;

  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] st = 2'd0;
  logic [1:0] it = 2'd0;
  logic load = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0]  count2;
  logic [11:0] count3;
  logic busy2, done2, clk_off2, busy3, done3, clk_off3;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Model: remaining seconds, cycles spent running toward next second, mode 0 idle / 1 run / 2 paused.
  int m_rem = 0;
  int m_acc = 0;
  int m_mode = 0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  irrigation_timer_bcd #(.DIGITS(2), .TICK_DIV(TICK)) dut2 (
    .clk(clk), .rst_n(rst_n), .state(st), .irrigation_type(it),
    .load(load), .pause(pause), .abort(abort),
    .count(count2), .busy(busy2), .done(done2), .clk_off(clk_off2)
  );

  irrigation_timer_bcd #(.DIGITS(3), .TICK_DIV(TICK)) dut3 (
    .clk(clk), .rst_n(rst_n), .state(st), .irrigation_type(it),
    .load(load), .pause(pause), .abort(abort),
    .count(count3), .busy(busy3), .done(done3), .clk_off(clk_off3)
  );

  function automatic int preset_int(input logic [1:0] s, input logic [1:0] t);
    case (s)
      2'd0: return 0;
      2'd1: return 10;
      2'd2: begin
        case (t)
          2'd0: return 45;
          2'd1: return 90;
          2'd2: return 30;
          default: return 0;
        endcase
      end
      default: return 5;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = 12'h000;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [11:0] b;
    logic bz, off;
    b = to_bcd(m_rem);
    bz = (m_mode != 0);
    off = (m_rem == 0);
    return {b[7:0], b, bz, bz, m_done, m_done, off, off};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {count2, count3, busy2, busy3, done2, done3, clk_off2, clk_off3};
  endfunction

  task automatic model_step();
    cyc++;
    m_done = 1'b0;
    if (!rst_n || abort) begin
      m_rem = 0; m_acc = 0; m_mode = 0;
    end else if (load) begin
      m_rem = preset_int(st, it);
      m_acc = 0;
      m_mode = (m_rem == 0) ? 0 : (pause ? 2 : 1);
    end else if (m_mode == 1) begin
      m_acc++;
      if (m_acc == TICK) begin
        m_acc = 0;
        m_rem--;
        if (m_rem == 0) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end
      if (m_mode == 1 && pause) m_mode = 2;
    end else if (m_mode == 2) begin
      if (!pause) m_mode = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; pause = 1'b1; st = 2'd2; it = 2'd1;
    cycle();
    cycle();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset got=%h want=%h", obs_vec(), exp_vec());
    end
    n_vec++;
    if ({count2, busy2, done2, clk_off2} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_values got=%h/%b%b%b want=00/001", count2, busy2, done2, clk_off2);
    end
    rst_n = 1'b1; load = 1'b0; pause = 1'b0;
    cycle();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_hold got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_drip();
    int done_at;
    st = 2'd2; it = 2'd1; load = 1'b1;
    cycle();
    load = 1'b0;
    n_vec++;
    if (count2 !== 8'h90 || busy2 !== 1'b1) begin
      n_err++; $display("FAIL drip_load got=%h busy=%b want=90 busy=1", count2, busy2);
    end
    done_at = -1;
    for (int k = 1; k <= 370; k++) begin
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL drip k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (k == 4) begin
        n_vec++;
        if (count2 !== 8'h89) begin
          n_err++; $display("FAIL drip_first_dec got=%h want=89", count2);
        end
      end
      if (done2 === 1'b1 && done_at < 0) done_at = k;
    end
    n_vec++;
    if (done_at !== 360 || clk_off2 !== 1'b1) begin
      n_err++; $display("FAIL drip_done at=%0d clk_off=%b want=360 clk_off=1", done_at, clk_off2);
    end
  endtask

  task automatic test_pause();
    int done_at;
    st = 2'd3; load = 1'b1;
    cycle();
    load = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      pause = (k >= 7 && k <= 16);
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL pause k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (done2 === 1'b1 && done_at < 0) done_at = k;
    end
    pause = 1'b0;
    n_vec++;
    if (done_at !== 30) begin
      n_err++; $display("FAIL pause_done at=%0d want=30", done_at);
    end
  endtask

  task automatic test_abort();
    bit seen_done;
    bit reached;
    st = 2'd2; it = 2'd0; load = 1'b1;
    cycle();
    load = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (m_rem == 30) begin
        reached = 1'b1;
        break;
      end
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL abort_run k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if (!reached || count2 !== 8'h30) begin
      n_err++; $display("FAIL abort_reach got=%h want=30", count2);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    n_vec++;
    if (count2 !== 8'h00 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      n_err++; $display("FAIL abort_clear got=%h busy=%b done=%b want=00 0 0", count2, busy2, done2);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL abort_idle k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (done2 === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done got=%b want=0", seen_done);
    end
    it = 2'd1; load = 1'b1; abort = 1'b1;
    cycle();
    load = 1'b0; abort = 1'b0;
    n_vec++;
    if (count2 !== 8'h00 || busy2 !== 1'b0) begin
      n_err++; $display("FAIL abort_over_load got=%h busy=%b want=00 0", count2, busy2);
    end
  endtask

  task automatic test_idle_load_borrow();
    st = 2'd0; load = 1'b1;
    cycle();
    load = 1'b0;
    n_vec++;
    if (count2 !== 8'h00 || busy2 !== 1'b0 || clk_off2 !== 1'b1) begin
      n_err++; $display("FAIL idle_load got=%h busy=%b clk_off=%b want=00 0 1", count2, busy2, clk_off2);
    end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL idle_hold k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    st = 2'd1; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) cycle();
    n_vec++;
    if (count2 !== 8'h09 || count3 !== 12'h009) begin
      n_err++; $display("FAIL borrow got=%h/%h want=09/009", count2, count3);
    end
  endtask

  task automatic test_reset_midrun();
    bit reached;
    st = 2'd1; load = 1'b1;
    cycle();
    load = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_rem == 7) begin
        reached = 1'b1;
        break;
      end
      cycle();
    end
    n_vec++;
    if (!reached || count2 !== 8'h07) begin
      n_err++; $display("FAIL midrun_reach got=%h want=07", count2);
    end
    rst_n = 1'b0; load = 1'b1; pause = 1'b1;
    cycle();
    rst_n = 1'b1; load = 1'b0; pause = 1'b0;
    n_vec++;
    if ({count2, busy2, done2, clk_off2} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL midrun_reset got=%h/%b%b%b want=00/001", count2, busy2, done2, clk_off2);
    end
    st = 2'd2; it = 2'd0; load = 1'b1;
    cycle();
    load = 1'b0;
    n_vec++;
    if (count3 !== 12'h045 || busy3 !== 1'b1) begin
      n_err++; $display("FAIL digits3 got=%h busy=%b want=045 1", count3, busy3);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      load  = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      st = 2'($urandom);
      it = 2'($urandom);
      cycle();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b1; load = 1'b0; abort = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drip();
    test_pause();
    test_abort();
    test_idle_load_borrow();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irrigation_timer_bcd.md
IRRIGATION_TIMER_BCD -- requirements
Module: irrigation_timer_bcd

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits in the countdown value; legal range 2..6.
REQ-002 Parameter TICK_DIV, default 50_000_000: clk cycles per one-second countdown step; legal range 1..2^26.
REQ-003 clk  input  1: single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 state  input  2: controller state code used to select the preset.
REQ-006 irrigation_type  input  2: irrigation type code used to select the preset in the irrigate state.
REQ-007 load  input  1: single-cycle pulse; capture the preset and start the countdown.
REQ-008 pause  input  1: level; freezes the countdown while high.
REQ-009 abort  input  1: single-cycle pulse; clears the count and returns to idle.
REQ-010 count  output  4*DIGITS: BCD remaining seconds; digit 0 (units) is bits [3:0].
REQ-011 busy  output  1: high in RUN or PAUSED.
REQ-012 done  output  1: one-cycle pulse when the count expires naturally.
REQ-013 clk_off  output  1: high when count equals zero; equals NOT of the OR of all count bits.

Function
REQ-014 Preset selection is combinational from (state, irrigation_type):
- state 00 (idle) -> 0
- state 01 (valve open) -> 10
- state 10 (irrigate), by irrigation_type: 00 sprinkler -> 45; 01 drip -> 90; 10 mist -> 30; 11 -> 0
- state 11 (drain) -> 5
REQ-015 Presets are zero-extended to DIGITS digits.
REQ-016 The FSM has states IDLE, RUN and PAUSED; the reset state is IDLE.
REQ-017 load in any state SHALL, on the next edge, write the preset to count and clear the prescaler.
- The FSM goes to RUN if the preset is non-zero, otherwise to IDLE.
- If pause is high in the same cycle and the preset is non-zero, the FSM goes to PAUSED instead.
REQ-018 Prescaler: a counter 0..TICK_DIV-1 that advances only in RUN and holds in PAUSED.
- On reaching TICK_DIV-1 it wraps to 0 and the count decrements by one.
- The first decrement after load occurs exactly TICK_DIV cycles after the load edge.
REQ-019 Decrement is BCD with borrow: a digit at 0 becomes 9 and borrows from the next digit; count never wraps below zero.
REQ-020 When a decrement takes count from 1 to 0, the FSM SHALL enter IDLE and pulse done high for that one cycle.
REQ-021 RUN with pause high -> PAUSED on the next edge; PAUSED with pause low -> RUN; count and prescaler are frozen while PAUSED.
REQ-022 abort SHALL clear count and prescaler and force IDLE on the next edge, without asserting done.
REQ-023 abort has priority over load, which has priority over a tick or a pause transition.
REQ-024 A load arriving in the same cycle as a tick reloads and does not decrement.
REQ-025 In IDLE, count holds its value and the prescaler is held at 0.
REQ-026 busy, done and clk_off are registered outputs or direct decodes of registered state; they have no combinational path from load, abort or pause.

Reset
REQ-027 With rst_n low at a rising edge, on that edge:
- count = 0
- prescaler = 0
- FSM = IDLE
- done = 0, busy = 0
- clk_off = 1
REQ-028 rst_n low mid-countdown SHALL behave as abort without done; rst_n low overrides load, abort and pause in the same cycle.

Structure
REQ-029 Package irrigation_timer_pkg SHALL hold:
- the state and irrigation_type code constants
- the FSM state encoding
- the preset table values in BCD
REQ-030 Sub-module bcd_digit_down SHALL implement one 4-bit BCD digit (inputs borrow_in and load value; outputs digit and borrow_out) and be instantiated DIGITS times.
REQ-031 The clock SHALL NOT be gated; the countdown is paced by the prescaler enable, replacing clock gating.

Verification (TICK_DIV=4, DIGITS=2)
REQ-032 state=10, irrigation_type=01, load -> count=0x90, busy=1; count=0x89 after 4 cycles; done pulses exactly 360 cycles after load; clk_off=1 afterward.
REQ-033 state=11, load; pause high for 10 cycles after 6 cycles -> count frozen during pause; done at 20+10 cycles after load.
REQ-034 state=10, irrigation_type=00, load; abort at count=0x30 -> count=0, IDLE, done never asserted; load and abort in the same cycle -> abort wins.
REQ-035 state=00, load -> count=0, busy=0, clk_off=1, no done; count 0x10 -> 0x09 borrow checked.
REQ-036 rst_n low for one edge mid-run (count=0x07) -> all outputs at reset values next cycle; rerun with DIGITS=3 shows count=0x045 for sprinkler.
